dcache_miss_controller: RTL and testbench
=========================================

// Module: dcache_miss_controller
// PURPOSE
//  Miss-status controller (MSHR queue) for the Dcache. Accepts block-address misses from the
//  load/store path and merges duplicates. Issues requests in order to the memory arbiter and
//  captures the returned transaction tags. When memory answers, it presents the refill block
//  to the Dcache write port. It sequences every Dcache refill.
// PARAMETERS
//  MSHR_DEPTH     4   outstanding-miss entries (power of 2, >=2)
//  BLK_ADDR_BITS  29  block address width (byte address >> 3)
// PORTS
//  clock           in   1              system clock, all state updates on posedge
//  reset           in   1              synchronous, active-low
//  miss_valid      in   1              Dcache reports a miss this cycle
//  miss_addr       in   BLK_ADDR_BITS  missing block address
//  miss_ready      out  1              miss accepted (allocated or merged) this cycle
//  mem_req_valid   out  1              request pending toward the arbiter
//  mem_req_addr    out  BLK_ADDR_BITS  block address of the oldest unissued entry
//  mem_req_accepted in  1              arbiter granted memory this cycle
//  current_req_tag in   MEM_TAG        tag from memory for the granted request; 0 = rejected
//  mem_data        in   MEM_BLOCK      returning block
//  mem_data_tag    in   MEM_TAG        tag of mem_data; 0 = no data
//  fill_valid      out  1              write fill_data into the Dcache line for fill_addr
//  fill_addr       out  BLK_ADDR_BITS  refill block address
//  fill_data       out  MEM_BLOCK      refill data
//  mshr_full       out  1              all entries valid
//  mshr_empty      out  1              no entries valid
//  tag_err         out  1              sticky: returned tag matched a non-head entry
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all entries invalid, head/issue/tail pointers = 0,
//    fill_valid=0, fill_addr=0, fill_data=0, tag_err=0. A reset mid-operation discards
//    in-flight misses. Responses arriving after reset match nothing and are ignored.
//  - Entry = {valid, issued, blk_addr, mem_tag}. It is a circular FIFO with pointers
//    head, issue and tail; each has one wrap bit.
//  - Allocation (combinational):
//      - If miss_valid and miss_addr equals the blk_addr of any valid entry, assert
//        miss_ready and allocate nothing (merge).
//      - Otherwise, if !mshr_full, assert miss_ready and write the entry at tail next cycle.
//      - If full, miss_ready=0.
//    Full and merge are judged on the pre-edge state: a same-cycle pop does not free a slot,
//    and the head being filled still counts for merge.
//  - Issue:
//      - mem_req_valid=1 when the entry at issue is valid and !issued.
//      - mem_req_addr = that entry's blk_addr (0 when idle).
//      - On mem_req_accepted && current_req_tag!=0: store the tag, set issued, advance issue.
//      - On accepted with tag 0: nothing changes; the same request is retried next cycle.
//  - Fill:
//      - mem_data_tag!=0 and equal to the head entry's mem_tag (head valid and issued):
//        at the next posedge, fill_valid=1, fill_addr=head.blk_addr, fill_data=mem_data.
//        The head is invalidated and advances.
//      - fill_valid is high for exactly one cycle per response (1-cycle registered latency).
//      - A nonzero tag matching a valid, issued, non-head entry sets tag_err (memory
//        returns in order). A tag matching no valid entry is ignored.
//  - Simultaneous allocate, issue and fill in one cycle are all legal and independent.
//    An entry allocated at cycle N can issue at N+1 at the earliest.
//  - Pointer wrap: index = low bits; full = equal index and differing wrap bit;
//    empty = identical pointers.
//  - Memory-tag equality is a full MEM_TAG compare. Tag 0 is never stored.
// STRUCTURE
//  - D_MSHR_ENTRY struct and the MSHR_DEPTH default go in sys_defs.svh, next to MEM_TAG
//    and MEM_BLOCK.
//  - No sub-module: one always_ff for entries/pointers/fill registers, one always_comb for
//    merge compare, miss_ready, issue selection and tag match.
// TESTING
//  1. Reset held low for 2 cycles, then idle -> mshr_empty=1, mem_req_valid=0, fill_valid=0.
//  2. Miss 0x100, grant with tag 3, mem_data_tag=3 data 0xDEAD -> next cycle fill_valid=1,
//     fill_addr=0x100, fill_data=0xDEAD; mshr_empty=1 after.
//  3. Misses 0x100, 0x100, 0x200 -> 2 entries allocated, all three see miss_ready=1;
//     requests are issued 0x100 then 0x200.
//  4. Fill 4 distinct misses, then a 5th -> mshr_full=1, miss_ready=0. The same cycle a
//     fill pops the head, a miss is still refused; it is accepted the next cycle.
//  5. Grant with current_req_tag=0 -> mem_req_valid stays 1 with the same address; the
//     retry gets tag 5 and the entry records 5.
//  6. Two entries issued (tags 2, 7); return tag 7 first -> tag_err=1, no fill. Reset low
//     mid-operation -> all entries cleared; a later tag 2 return produces no fill.

Source files
------------

// File: rtl/dcache_miss_controller_pkg.sv
// Shared types for the Dcache miss-status (MSHR) controller.
// Memory tag/block widths and default queue geometry live here.
package dcache_miss_controller_pkg;

    localparam int DEF_MSHR_DEPTH    = 4;
    localparam int DEF_BLK_ADDR_BITS = 29;
    localparam int MEM_TAG_BITS      = 4;
    localparam int MEM_BLOCK_BITS    = 64;

    typedef logic [MEM_TAG_BITS-1:0]   mem_tag_t;
    typedef logic [MEM_BLOCK_BITS-1:0] mem_block_t;

    // Tag 0 means "no transaction" on every memory-side tag bus.
    function automatic logic tag_live(input mem_tag_t t);
        return t != '0;
    endfunction

endpackage

// File: rtl/dcache_miss_controller.sv
// MSHR queue: merges duplicate misses, issues in order,
// and sequences one-cycle refills back into the Dcache.
module dcache_miss_controller
    import dcache_miss_controller_pkg::*;
#(
    parameter int MSHR_DEPTH    = DEF_MSHR_DEPTH,
    parameter int BLK_ADDR_BITS = DEF_BLK_ADDR_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     miss_valid,
    input  logic [BLK_ADDR_BITS-1:0] miss_addr,
    output logic                     miss_ready,
    output logic                     mem_req_valid,
    output logic [BLK_ADDR_BITS-1:0] mem_req_addr,
    input  logic                     mem_req_accepted,
    input  mem_tag_t                 current_req_tag,
    input  mem_block_t               mem_data,
    input  mem_tag_t                 mem_data_tag,
    output logic                     fill_valid,
    output logic [BLK_ADDR_BITS-1:0] fill_addr,
    output mem_block_t               fill_data,
    output logic                     mshr_full,
    output logic                     mshr_empty,
    output logic                     tag_err
);

    localparam int IDX_W = $clog2(MSHR_DEPTH);

    typedef logic [IDX_W:0]   ptr_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic                     valid;
        logic                     issued;
        logic [BLK_ADDR_BITS-1:0] blk_addr;
        mem_tag_t                 mem_tag;
    } d_mshr_entry_t;

    d_mshr_entry_t            ent_q [MSHR_DEPTH];
    ptr_t                     head_q;
    ptr_t                     issue_q;
    ptr_t                     tail_q;
    logic                     fill_valid_q;
    logic [BLK_ADDR_BITS-1:0] fill_addr_q;
    mem_block_t               fill_data_q;
    logic                     tag_err_q;

    idx_t          head_idx;
    idx_t          issue_idx;
    idx_t          tail_idx;
    d_mshr_entry_t head_ent;
    d_mshr_entry_t issue_ent;
    logic          full;
    logic          empty;
    logic          merge_hit;
    logic          alloc;
    logic          req_fire;
    logic          fill_hit;
    logic          stray_hit;

    assign head_idx  = head_q[IDX_W-1:0];
    assign issue_idx = issue_q[IDX_W-1:0];
    assign tail_idx  = tail_q[IDX_W-1:0];
    assign head_ent  = ent_q[head_idx];
    assign issue_ent = ent_q[issue_idx];

    // Merge compare, admission, issue selection and response tag match.
    always_comb begin
        full          = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
        empty         = (head_q == tail_q);
        merge_hit     = 1'b0;
        stray_hit     = 1'b0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].blk_addr == miss_addr) begin
                merge_hit = 1'b1;
            end
            if (ent_q[i].valid && ent_q[i].issued && tag_live(mem_data_tag) &&
                ent_q[i].mem_tag == mem_data_tag && i != int'(head_idx)) begin
                stray_hit = 1'b1;
            end
        end
        miss_ready    = miss_valid && (merge_hit || !full);
        alloc         = miss_valid && !merge_hit && !full;
        mem_req_valid = issue_ent.valid && !issue_ent.issued;
        mem_req_addr  = mem_req_valid ? issue_ent.blk_addr : '0;
        req_fire      = mem_req_valid && mem_req_accepted && tag_live(current_req_tag);
        fill_hit      = head_ent.valid && head_ent.issued && tag_live(mem_data_tag) &&
                        head_ent.mem_tag == mem_data_tag;
    end

    // Entry array, ring pointers and registered refill/error outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            head_q       <= '0;
            issue_q      <= '0;
            tail_q       <= '0;
            fill_valid_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            tag_err_q    <= 1'b0;
        end else begin
            if (req_fire) begin
                ent_q[issue_idx].issued  <= 1'b1;
                ent_q[issue_idx].mem_tag <= current_req_tag;
                issue_q                  <= issue_q + ptr_t'(1);
            end
            if (fill_hit) begin
                ent_q[head_idx].valid  <= 1'b0;
                ent_q[head_idx].issued <= 1'b0;
                head_q                 <= head_q + ptr_t'(1);
                fill_addr_q            <= head_ent.blk_addr;
                fill_data_q            <= mem_data;
            end
            if (alloc) begin
                ent_q[tail_idx] <= '{valid: 1'b1, issued: 1'b0,
                                     blk_addr: miss_addr, mem_tag: '0};
                tail_q          <= tail_q + ptr_t'(1);
            end
            fill_valid_q <= fill_hit;
            tag_err_q    <= tag_err_q | stray_hit;
        end
    end

    assign fill_valid = fill_valid_q;
    assign fill_addr  = fill_addr_q;
    assign fill_data  = fill_data_q;
    assign tag_err    = tag_err_q;
    assign mshr_full  = full;
    assign mshr_empty = empty;

endmodule

// File: tb/tb_dcache_miss_controller.sv
// Bench for dcache_miss_controller: queue-based reference model
// checked every cycle, directed scenarios, then random traffic.
module tb_dcache_miss_controller;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic [28:0] miss_addr;
    logic        miss_ready;
    logic        mem_req_valid;
    logic [28:0] mem_req_addr;
    logic        mem_req_accepted;
    logic [3:0]  current_req_tag;
    logic [63:0] mem_data;
    logic [3:0]  mem_data_tag;
    logic        fill_valid;
    logic [28:0] fill_addr;
    logic [63:0] fill_data;
    logic        mshr_full;
    logic        mshr_empty;
    logic        tag_err;

    int checks = 0;
    int errors = 0;

    dcache_miss_controller dut (
        .clock            (clk),
        .reset            (reset),
        .miss_valid       (miss_valid),
        .miss_addr        (miss_addr),
        .miss_ready       (miss_ready),
        .mem_req_valid    (mem_req_valid),
        .mem_req_addr     (mem_req_addr),
        .mem_req_accepted (mem_req_accepted),
        .current_req_tag  (current_req_tag),
        .mem_data         (mem_data),
        .mem_data_tag     (mem_data_tag),
        .fill_valid       (fill_valid),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data),
        .mshr_full        (mshr_full),
        .mshr_empty       (mshr_empty),
        .tag_err          (tag_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: outstanding misses in arrival order.
    typedef struct {
        logic [28:0] addr;
        bit          issued;
        logic [3:0]  tag;
    } mrec_t;

    mrec_t       mq[$];
    bit          model_ok = 0;
    bit          efv = 0;
    logic [28:0] efa = '0;
    logic [63:0] efd = '0;
    bit          eerr = 0;

    always @(negedge clk) begin : model
        int          ri;
        bit          mg;
        bit          fl;
        bit          fh;
        bit          se;
        bit          rv;
        logic [28:0] ra;
        mrec_t       r;
        fl = (mq.size() == DEPTH);
        mg = 0;
        foreach (mq[i]) if (mq[i].addr == miss_addr) mg = 1;
        mg = mg && miss_valid;
        ri = -1;
        foreach (mq[i]) if (ri < 0 && !mq[i].issued) ri = i;
        rv = (ri >= 0);
        ra = rv ? mq[ri].addr : 29'd0;
        fh = (mem_data_tag != 0) && (mq.size() > 0) && mq[0].issued &&
             (mq[0].tag == mem_data_tag);
        se = 0;
        for (int i = 1; i < mq.size(); i++)
            if (mq[i].issued && mem_data_tag != 0 && mq[i].tag == mem_data_tag) se = 1;
        if (model_ok) begin
            chk("miss_ready", 64'(miss_ready), 64'(miss_valid && (mg || !fl)));
            chk("req_valid", 64'(mem_req_valid), 64'(rv));
            chk("req_addr", 64'(mem_req_addr), 64'(ra));
            chk("full", 64'(mshr_full), 64'(fl));
            chk("empty", 64'(mshr_empty), 64'(mq.size() == 0));
            chk("fill_valid", 64'(fill_valid), 64'(efv));
            chk("tag_err", 64'(tag_err), 64'(eerr));
            if (efv) begin
                chk("fill_addr", 64'(fill_addr), 64'(efa));
                chk("fill_data", fill_data, efd);
            end
        end
        if (!reset) begin
            mq.delete();
            efv = 0; efa = '0; efd = '0; eerr = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (rv && mem_req_accepted && current_req_tag != 0) begin
                r = mq[ri];
                r.issued = 1;
                r.tag = current_req_tag;
                mq[ri] = r;
            end
            efv = fh;
            if (fh) begin
                efa = mq[0].addr;
                efd = mem_data;
                void'(mq.pop_front());
            end
            if (se) eerr = 1;
            if (miss_valid && !mg && !fl) begin
                r.addr = miss_addr;
                r.issued = 0;
                r.tag = '0;
                mq.push_back(r);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        miss_valid = 0; miss_addr = '0;
        mem_req_accepted = 0; current_req_tag = '0;
        mem_data = '0; mem_data_tag = '0;
    endtask

    function automatic logic [3:0] fresh_tag();
        logic [3:0] t;
        bit         used;
        t = 4'd1;
        for (int k = 0; k < 64; k++) begin
            t = 4'($urandom_range(1, 15));
            used = 0;
            foreach (mq[i]) if (mq[i].issued && mq[i].tag == t) used = 1;
            if (!used) return t;
        end
        return t;
    endfunction

    initial begin
        idle();
        reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("t1_empty", 64'(mshr_empty), 64'd1);
        chk("t1_req", 64'(mem_req_valid), 64'd0);
        chk("t1_fill", 64'(fill_valid), 64'd0);

        // Single miss round trip
        cyc(); miss_valid = 1; miss_addr = 29'h100;
        cyc(); miss_valid = 0; mem_req_accepted = 1; current_req_tag = 4'd3;
        @(negedge clk);
        chk("t2_req", 64'(mem_req_valid), 64'd1);
        chk("t2_addr", 64'(mem_req_addr), 64'h100);
        cyc(); mem_req_accepted = 0; current_req_tag = 0;
        mem_data_tag = 4'd3; mem_data = 64'hDEAD;
        cyc(); mem_data_tag = 0;
        @(negedge clk);
        chk("t2_fv", 64'(fill_valid), 64'd1);
        chk("t2_fa", 64'(fill_addr), 64'h100);
        chk("t2_fd", fill_data, 64'hDEAD);
        chk("t2_empty", 64'(mshr_empty), 64'd1);
        cyc();
        @(negedge clk);
        chk("t2_fv_drop", 64'(fill_valid), 64'd0);

        // Merge of duplicate miss, in-order issue
        cyc(); miss_valid = 1; miss_addr = 29'h100;
        @(negedge clk); chk("t3_rdy0", 64'(miss_ready), 64'd1);
        cyc(); miss_addr = 29'h100;
        @(negedge clk); chk("t3_rdy1", 64'(miss_ready), 64'd1);
        cyc(); miss_addr = 29'h200;
        @(negedge clk); chk("t3_rdy2", 64'(miss_ready), 64'd1);
        cyc(); miss_valid = 0; mem_req_accepted = 1; current_req_tag = 4'd1;
        @(negedge clk); chk("t3_iss0", 64'(mem_req_addr), 64'h100);
        cyc(); current_req_tag = 4'd2;
        @(negedge clk); chk("t3_iss1", 64'(mem_req_addr), 64'h200);
        cyc(); mem_req_accepted = 0; current_req_tag = 0;
        @(negedge clk);
        chk("t3_noreq", 64'(mem_req_valid), 64'd0);
        chk("t3_nempty", 64'(mshr_empty), 64'd0);
        cyc(); mem_data_tag = 4'd1; mem_data = 64'h1111;
        cyc(); mem_data_tag = 4'd2; mem_data = 64'h2222;
        cyc(); mem_data_tag = 0;
        @(negedge clk); chk("t3_drained", 64'(mshr_empty), 64'd1);

        // Full queue, refusal while head pops
        for (int i = 0; i < 4; i++) begin
            cyc(); miss_valid = 1; miss_addr = 29'(32'h10 + i);
        end
        cyc(); miss_addr = 29'h14;
        @(negedge clk);
        chk("t4_full", 64'(mshr_full), 64'd1);
        chk("t4_refuse", 64'(miss_ready), 64'd0);
        cyc(); mem_req_accepted = 1; current_req_tag = 4'd4;
        cyc(); mem_req_accepted = 0; current_req_tag = 0;
        mem_data_tag = 4'd4; mem_data = 64'h4444;
        @(negedge clk); chk("t4_pop_refuse", 64'(miss_ready), 64'd0);
        cyc(); mem_data_tag = 0;
        @(negedge clk);
        chk("t4_accept", 64'(miss_ready), 64'd1);
        chk("t4_fa", 64'(fill_addr), 64'h10);
        cyc(); miss_valid = 0; reset = 0;
        cyc(); reset = 1;

        // Rejected grant is retried
        cyc(); miss_valid = 1; miss_addr = 29'h300;
        cyc(); miss_valid = 0; mem_req_accepted = 1; current_req_tag = 0;
        @(negedge clk); chk("t5_req", 64'(mem_req_addr), 64'h300);
        cyc(); current_req_tag = 4'd5;
        @(negedge clk);
        chk("t5_retry_v", 64'(mem_req_valid), 64'd1);
        chk("t5_retry_a", 64'(mem_req_addr), 64'h300);
        cyc(); mem_req_accepted = 0; current_req_tag = 0;
        @(negedge clk); chk("t5_issued", 64'(mem_req_valid), 64'd0);
        cyc(); mem_data_tag = 4'd5; mem_data = 64'h5555;
        cyc(); mem_data_tag = 0;
        @(negedge clk);
        chk("t5_fv", 64'(fill_valid), 64'd1);
        chk("t5_fa", 64'(fill_addr), 64'h300);

        // Out-of-order tag, then reset discards in-flight work
        cyc(); miss_valid = 1; miss_addr = 29'h400;
        cyc(); miss_addr = 29'h500;
        cyc(); miss_valid = 0; mem_req_accepted = 1; current_req_tag = 4'd2;
        cyc(); current_req_tag = 4'd7;
        cyc(); mem_req_accepted = 0; current_req_tag = 0;
        mem_data_tag = 4'd7; mem_data = 64'h7777;
        cyc(); mem_data_tag = 0;
        @(negedge clk);
        chk("t6_err", 64'(tag_err), 64'd1);
        chk("t6_nofill", 64'(fill_valid), 64'd0);
        cyc(); reset = 0;
        cyc(); reset = 1; mem_data_tag = 4'd2; mem_data = 64'h2222;
        cyc(); mem_data_tag = 0;
        @(negedge clk);
        chk("t6_late_fill", 64'(fill_valid), 64'd0);
        chk("t6_err_clr", 64'(tag_err), 64'd0);
        chk("t6_empty", 64'(mshr_empty), 64'd1);

        // Random traffic against the model
        repeat (3000) begin
            cyc();
            idle();
            reset = ($urandom_range(0, 299) != 0);
            miss_valid = ($urandom_range(0, 1) == 1);
            miss_addr = 29'(32'h40 + $urandom_range(0, 5));
            if (mem_req_valid && $urandom_range(0, 9) < 6) begin
                mem_req_accepted = 1;
                current_req_tag = ($urandom_range(0, 4) == 0) ? 4'd0 : fresh_tag();
            end
            mem_data = {$urandom, $urandom};
            if (mq.size() > 0 && mq[0].issued && $urandom_range(0, 1) == 1)
                mem_data_tag = mq[0].tag;
            else if ($urandom_range(0, 49) == 0)
                mem_data_tag = 4'($urandom_range(1, 15));
        end
        cyc();
        idle();
        reset = 1;
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
